// File: rtl/phys_freelist.sv
`default_nettype none
// ============================================================================
// phys_freelist : bitmap free list of physical registers; offers the N lowest
//                 free PRs per cycle, reclaims retired PRs, reloads on recovery.
// Revision      : 1.0
// ============================================================================
module phys_freelist #(
   parameter  int N          = 3,
   parameter  int PHYS_REGS  = 64,
   parameter  int ARCH_COUNT = 32,
   localparam int PRW        = $clog2(PHYS_REGS),
   localparam int CW         = $clog2(PHYS_REGS + 1),
   localparam int AW         = $clog2(N + 1)
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [AW-1:0]            alloc_count,
   input  logic [PHYS_REGS-1:0]     free_mask,
   input  logic                     restore_en,
   input  logic [PHYS_REGS-1:0]     restore_mask,
   output logic [N-1:0][PRW-1:0]    offer_phys,
   output logic [N-1:0]             offer_valid,
   output logic [CW-1:0]            free_count
);

   localparam logic [PHYS_REGS-1:0] RESET_BITS =
      {{(PHYS_REGS-ARCH_COUNT){1'b1}}, {ARCH_COUNT{1'b0}}};
   localparam logic [CW-1:0] RESET_COUNT = CW'(PHYS_REGS - ARCH_COUNT);

   logic [PHYS_REGS-1:0] free_bits;
   logic [PHYS_REGS-1:0] free_bits_n;
   logic [PHYS_REGS-1:0] remaining;
   logic [PHYS_REGS-1:0] taken_mask;
   logic [CW-1:0]        count_n;
   logic [AW-1:0]        valid_count;
   logic                 found;

   // Each lane claims the lowest bit still left after the lanes below it.
   always_comb begin
      remaining   = free_bits;
      offer_phys  = '0;
      offer_valid = '0;
      found       = 1'b0;
      for (int k = 0; k < N; k++) begin
         found = 1'b0;
         for (int i = 0; i < PHYS_REGS; i++) begin
            if (!found && remaining[i]) begin
               offer_phys[k] = PRW'(i);
               remaining[i]  = 1'b0;
               found         = 1'b1;
            end
         end
         offer_valid[k] = found;
      end
   end

   // Valid lanes form a prefix, so gating on offer_valid clamps alloc_count.
   always_comb begin
      taken_mask  = '0;
      valid_count = '0;
      for (int k = 0; k < N; k++) begin
         if (offer_valid[k]) begin
            valid_count = valid_count + AW'(1);
            if (AW'(k) < alloc_count)
               taken_mask[offer_phys[k]] = 1'b1;
         end
      end
      if (restore_en)
         free_bits_n = restore_mask;
      else
         free_bits_n = (free_bits & ~taken_mask) | free_mask;
      free_bits_n[0] = 1'b0;
      count_n = '0;
      for (int i = 0; i < PHYS_REGS; i++)
         count_n = count_n + CW'(free_bits_n[i]);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         free_bits  <= RESET_BITS;
         free_count <= RESET_COUNT;
      end else begin
         free_bits  <= free_bits_n;
         free_count <= count_n;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset && !restore_en) begin
         a_alloc_overrun: assert (alloc_count <= valid_count);
         a_take_and_free: assert ((taken_mask & free_mask) == '0);
         a_double_free:   assert ((free_bits & free_mask) == '0);
      end
   end

endmodule
`default_nettype wire
